// File: rtl/serial_sub_8bit_pkg.sv
// rtl/serial_sub_8bit_pkg.sv - shared state encoding and default width for the serial subtractor
package serial_sub_8bit_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - 1-bit full adder cell
module full_adder (
  input  logic in1,
  input  logic in2,
  input  logic cin,
  output logic out,
  output logic cout
);

  assign out  = in1 ^ in2 ^ cin;
  assign cout = (in1 & in2) | (cin & (in1 ^ in2));

endmodule

// File: rtl/serial_sub_8bit.sv
// rtl/serial_sub_8bit.sv - bit-serial subtractor, in1 - in2 - bin, LSB first through one full adder
module serial_sub_8bit
  import serial_sub_8bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc;
  logic             c;
  logic             nb;
  logic             s;
  logic             co;
  logic             last;

  assign last = (cnt == CW'(WIDTH - 1));
  assign nb   = ~b[0];
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // a - b - bin is formed as a + ~b + ~bin, so the carry chain starts at ~bin
  full_adder u_fa (
    .in1  (a[0]),
    .in2  (nb),
    .cin  (c),
    .out  (s),
    .cout (co)
  );

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = RUN;
      RUN:     if (last) next = DONE;
      DONE:    next = start ? RUN : IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      c     <= 1'b0;
      a     <= '0;
      b     <= '0;
      acc   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= next;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a   <= in1;
            b   <= in2;
            c   <= ~bin;
            cnt <= '0;
          end
        end
        RUN: begin
          a   <= a >> 1;
          b   <= b >> 1;
          acc <= {s, acc[WIDTH-1:1]};
          c   <= co;
          cnt <= cnt + CW'(1);
          // c still holds the carry into the MSB on the final bit
          if (last) begin
            diff <= {s, acc[WIDTH-1:1]};
            bout <= ~co;
            ovf  <= c ^ co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
